axi_lite_mem_arbiter: RTL
=========================

// Module: axi_lite_mem_arbiter
// PURPOSE
//  2:1 AXI4-Lite arbiter sharing one memory slave (axi_memory_mock or BRAM controller) between
//  the riscv_cpu instruction-fetch master (port S0) and load/store master (port S1).
//  Serialises transactions, one outstanding at a time, and holds the grant until the response
//  handshake completes. Sits between the CPU master ports and the single memory slave in the
//  full_cpu bench and the FPGA top.
// PARAMETERS
//  ADDR_WIDTH   `AXI_ADDR_WIDTH (32)   address width, all ports
//  DATA_WIDTH   `AXI_DATA_WIDTH (32)   data width; strobe width = DATA_WIDTH/8
// PORTS
//  CLK                      in   1    system clock, all logic on rising edge
//  RSTn                     in   1    asynchronous, active-low reset
//  S0_AXI_*, S1_AXI_*       slv  AXI4-Lite slave sets (AW/W/B/AR/R, incl. PROT, STRB, RESP), widths per params
//  M_AXI_*                  mst  AXI4-Lite master set to memory, same signal list
//  grant_o                  out  2    one-hot current owner {S1,S0}; 2'b00 when idle
//  busy_o                   out  1    1 while any transaction is in flight
// BEHAVIOUR
//  - Request: port requests when ARVALID or AWVALID is high. Within a port, a pending write beats a read.
//  - FSM: IDLE -> RD_ADDR -> RD_DATA -> IDLE; IDLE -> WR_ADDR -> WR_RESP -> IDLE.
//    IDLE: sample requests, register grant and direction at clock edge (1-cycle arbitration bubble).
//    RD_ADDR: M_ARVALID/ARADDR/ARPROT = granted S*_AR*; ARREADY passed back. On AR handshake -> RD_DATA.
//    RD_DATA: R channel routed to granted port. On RVALID&RREADY -> IDLE, grant cleared.
//    WR_ADDR: AW and W routed independently; aw_done/w_done flags set on each handshake (same cycle
//      allowed). When both are set -> WR_RESP. No AW or W is forwarded twice.
//    WR_RESP: B channel routed. On BVALID&BREADY -> IDLE, flags cleared.
//  - Routing is combinational from registered grant/state; no data registers, zero added latency once granted.
//  - Ungranted ports see all READY/VALID = 0, RDATA = 0, RESP = 0. RESP and RDATA pass through unchanged.
//  - Master side: all VALID/READY = 0 and ADDR/DATA/STRB/PROT = 0 whenever state is IDLE.
//  - Request withdrawn after grant (protocol violation): arbiter waits; it does not abort.
//  - Back-to-back: same port may re-request in the IDLE cycle that follows; a bubble cycle is always inserted.
//  - Reset (any time, incl. mid-transaction): state IDLE, grant_o = 0, busy_o = 0, flags 0, all outputs 0
//    asynchronously; in-flight transaction is dropped (memory slave is reset by the same RSTn).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous S0/S1 requests, port not granted last wins; last-grant
//    register resets to S1 (so S0 wins the first tie).
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, S1 (data) always beats S0 (fetch); no last-grant register.
// TESTING
//  1 Reset: RSTn=0 mid-RD_DATA -> grant_o=00, busy_o=0, M_AXI_ARVALID=0, S0_AXI_RVALID=0 same cycle.
//  2 S0 read 0x0000_0010, memory word 0x0000_0093 -> S0 RDATA=0x93, RRESP=0, grant_o=01 then 00; S1 idle all 0.
//  3 S1 write 0x0000_0004 data 0xDEAD_BEEF strb 4'b1111, W 2 cycles after AW -> one M AW and one M W,
//    d_data[1]=0xDEADBEEF, S1 BVALID once, BRESP=0.
//  4 S0 and S1 request reads in same cycle, fixed prio -> S1 served first, S0 next; RR -> S0 first,
//    then S1; repeat tie -> S1 then S0 (alternation).
//  5 S1 asserts AWVALID and ARVALID together -> write completes before read; read then issued after bubble.
//  6 Stress: 200 random interleaved S0/S1 reads/writes with random slave READY stalls -> scoreboard
//    matches memory model; no port ever sees VALID without own request; busy_o never drops mid-transaction.

Source files
------------

// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter: 2:1 AXI4-Lite arbiter, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed S1 priority.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi_lite_mem_arbiter #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  // S0: instruction fetch
  input  logic [ADDR_WIDTH-1:0] S0_AXI_AWADDR,
  input  logic [2:0]            S0_AXI_AWPROT,
  input  logic                  S0_AXI_AWVALID,
  output logic                  S0_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0] S0_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0] S0_AXI_WSTRB,
  input  logic                  S0_AXI_WVALID,
  output logic                  S0_AXI_WREADY,
  output logic [1:0]            S0_AXI_BRESP,
  output logic                  S0_AXI_BVALID,
  input  logic                  S0_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S0_AXI_ARADDR,
  input  logic [2:0]            S0_AXI_ARPROT,
  input  logic                  S0_AXI_ARVALID,
  output logic                  S0_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0] S0_AXI_RDATA,
  output logic [1:0]            S0_AXI_RRESP,
  output logic                  S0_AXI_RVALID,
  input  logic                  S0_AXI_RREADY,
  // S1: load/store
  input  logic [ADDR_WIDTH-1:0] S1_AXI_AWADDR,
  input  logic [2:0]            S1_AXI_AWPROT,
  input  logic                  S1_AXI_AWVALID,
  output logic                  S1_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0] S1_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0] S1_AXI_WSTRB,
  input  logic                  S1_AXI_WVALID,
  output logic                  S1_AXI_WREADY,
  output logic [1:0]            S1_AXI_BRESP,
  output logic                  S1_AXI_BVALID,
  input  logic                  S1_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S1_AXI_ARADDR,
  input  logic [2:0]            S1_AXI_ARPROT,
  input  logic                  S1_AXI_ARVALID,
  output logic                  S1_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0] S1_AXI_RDATA,
  output logic [1:0]            S1_AXI_RRESP,
  output logic                  S1_AXI_RVALID,
  input  logic                  S1_AXI_RREADY,
  // M: shared memory slave
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_q, last_d;
`endif

  logic req0, req1, pick1, sel1;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic [ADDR_WIDTH-1:0] s_awaddr, s_araddr;
  logic [2:0]            s_awprot, s_arprot;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [STRB_WIDTH-1:0] s_wstrb;
  logic s_awvalid, s_wvalid, s_bready;
  logic s_arvalid, s_rready;

  logic                  r_arready, r_rvalid;
  logic                  r_awready, r_wready, r_bvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp, r_bresp;

  assign req0 = S0_AXI_ARVALID | S0_AXI_AWVALID;
  assign req1 = S1_AXI_ARVALID | S1_AXI_AWVALID;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick1 = req1 & (~req0 | ~last_q);
`else
  assign pick1 = req1;
`endif

  assign sel1      = grant_q[1];
  assign s_awaddr  = sel1 ? S1_AXI_AWADDR  : S0_AXI_AWADDR;
  assign s_awprot  = sel1 ? S1_AXI_AWPROT  : S0_AXI_AWPROT;
  assign s_awvalid = sel1 ? S1_AXI_AWVALID : S0_AXI_AWVALID;
  assign s_wdata   = sel1 ? S1_AXI_WDATA   : S0_AXI_WDATA;
  assign s_wstrb   = sel1 ? S1_AXI_WSTRB   : S0_AXI_WSTRB;
  assign s_wvalid  = sel1 ? S1_AXI_WVALID  : S0_AXI_WVALID;
  assign s_bready  = sel1 ? S1_AXI_BREADY  : S0_AXI_BREADY;
  assign s_araddr  = sel1 ? S1_AXI_ARADDR  : S0_AXI_ARADDR;
  assign s_arprot  = sel1 ? S1_AXI_ARPROT  : S0_AXI_ARPROT;
  assign s_arvalid = sel1 ? S1_AXI_ARVALID : S0_AXI_ARVALID;
  assign s_rready  = sel1 ? S1_AXI_RREADY  : S0_AXI_RREADY;

  // Channel routing: purely combinational from registered state/grant
  always_comb begin
    M_AXI_AWADDR  = '0;
    M_AXI_AWPROT  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARPROT  = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    r_arready     = 1'b0;
    r_rvalid      = 1'b0;
    r_rdata       = '0;
    r_rresp       = '0;
    r_awready     = 1'b0;
    r_wready      = 1'b0;
    r_bvalid      = 1'b0;
    r_bresp       = '0;
    unique case (state_q)
      RD_ADDR: begin
        M_AXI_ARADDR  = s_araddr;
        M_AXI_ARPROT  = s_arprot;
        M_AXI_ARVALID = s_arvalid;
        r_arready     = M_AXI_ARREADY;
      end
      RD_DATA: begin
        M_AXI_RREADY = s_rready;
        r_rvalid     = M_AXI_RVALID;
        r_rdata      = M_AXI_RDATA;
        r_rresp      = M_AXI_RRESP;
      end
      WR_ADDR: begin
        M_AXI_AWADDR  = s_awaddr;
        M_AXI_AWPROT  = s_awprot;
        M_AXI_AWVALID = s_awvalid & ~aw_done_q;
        r_awready     = M_AXI_AWREADY & ~aw_done_q;
        M_AXI_WDATA   = s_wdata;
        M_AXI_WSTRB   = s_wstrb;
        M_AXI_WVALID  = s_wvalid & ~w_done_q;
        r_wready      = M_AXI_WREADY & ~w_done_q;
      end
      WR_RESP: begin
        M_AXI_BREADY = s_bready;
        r_bvalid     = M_AXI_BVALID;
        r_bresp      = M_AXI_BRESP;
      end
      default: ;
    endcase
  end

  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY & M_AXI_RVALID;
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY & M_AXI_BVALID;

  assign S0_AXI_ARREADY = grant_q[0] & r_arready;
  assign S0_AXI_RVALID  = grant_q[0] & r_rvalid;
  assign S0_AXI_RDATA   = grant_q[0] ? r_rdata : '0;
  assign S0_AXI_RRESP   = grant_q[0] ? r_rresp : '0;
  assign S0_AXI_AWREADY = grant_q[0] & r_awready;
  assign S0_AXI_WREADY  = grant_q[0] & r_wready;
  assign S0_AXI_BVALID  = grant_q[0] & r_bvalid;
  assign S0_AXI_BRESP   = grant_q[0] ? r_bresp : '0;

  assign S1_AXI_ARREADY = grant_q[1] & r_arready;
  assign S1_AXI_RVALID  = grant_q[1] & r_rvalid;
  assign S1_AXI_RDATA   = grant_q[1] ? r_rdata : '0;
  assign S1_AXI_RRESP   = grant_q[1] ? r_rresp : '0;
  assign S1_AXI_AWREADY = grant_q[1] & r_awready;
  assign S1_AXI_WREADY  = grant_q[1] & r_wready;
  assign S1_AXI_BVALID  = grant_q[1] & r_bvalid;
  assign S1_AXI_BRESP   = grant_q[1] ? r_bresp : '0;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          if (pick1 ? S1_AXI_AWVALID : S0_AXI_AWVALID) begin
            state_d = WR_ADDR;
          end else begin
            state_d = RD_ADDR;
          end
`ifdef ARB_ROUND_ROBIN_EN
          // tie-break memory only moves when both ports contend
          if (req0 & req1) last_d = pick1;
`endif
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      WR_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d & w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d   = IDLE;
          grant_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule
